// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types for the IFU fetch queue: entry layout and default sizing.
package ifu_fetch_queue_pkg;

    localparam int XLEN         = 32;
    localparam int INSTR_LEN    = 32;
    localparam int FETCHQ_DEPTH = 4;
    localparam int FETCHQ_SKID  = 2;

    typedef struct packed {
        logic                 pred_taken;
        logic [XLEN-1:0]      tag;
        logic [INSTR_LEN-1:0] instr;
    } fetchq_entry_t;

    localparam int FETCHQ_ENTRY_W = $bits(fetchq_entry_t);

endpackage

// File: rtl/ifu_fetch_queue_storage.sv
// Fetch queue entry array: one synchronous write port, one asynchronous read port.
// Not reset; the control logic masks the outputs whenever the head is invalid.
module ifu_fetch_queue_storage
    import ifu_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_waddr,
    input  logic [FETCHQ_ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]             i_raddr,
    output logic [FETCHQ_ENTRY_W-1:0] o_rdata
);

    logic [FETCHQ_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// FIFO between the IFU output register and decode, with early fetch back-pressure and one-cycle flush.
// Optional same-cycle empty-queue bypass from in_* to out_* when FETCHQ_BYPASS_EN is defined.
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,
    parameter int SKID  = FETCHQ_SKID
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    input  logic [INSTR_LEN-1:0]       i_in_instr,
    input  logic [XLEN-1:0]            i_in_tag,
    input  logic                       i_in_pred_taken,
    output logic                       o_fetch_stall,
    output logic                       o_out_valid,
    output logic [INSTR_LEN-1:0]       o_out_instr,
    output logic [XLEN-1:0]            o_out_tag,
    output logic                       o_out_pred_taken,
    input  logic                       i_out_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_STALL = CW'(DEPTH - SKID);

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    fetchq_entry_t w_wdata;
    fetchq_entry_t w_rdata;
    fetchq_entry_t w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_bypass_take;

    assign w_wdata = '{pred_taken: i_in_pred_taken, tag: i_in_tag, instr: i_in_instr};
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && i_out_ready;

`ifdef FETCHQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = w_empty && i_in_valid && !i_flush;
    assign w_bypass_take = w_bypass && i_out_ready;
    assign w_head        = w_bypass ? w_wdata : w_rdata;
    assign w_out_valid   = !w_empty || w_bypass;
`else
    assign w_bypass_take = 1'b0;
    assign w_head        = w_rdata;
    assign w_out_valid   = !w_empty;
`endif

    // A pop at full frees its slot in the same cycle, so the push still lands.
    assign w_push = i_in_valid && (!w_full || w_pop) && !w_bypass_take;
    assign w_drop = i_in_valid && w_full && !w_pop;

    ifu_fetch_queue_storage #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_storage (
        .i_clk   (i_clk),
        .i_we    (w_push && !i_flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign o_out_valid      = w_out_valid;
    assign o_out_instr      = w_out_valid ? w_head.instr      : '0;
    assign o_out_tag        = w_out_valid ? w_head.tag        : '0;
    assign o_out_pred_taken = w_out_valid ? w_head.pred_taken : 1'b0;
    assign o_fetch_stall    = (r_count >= CNT_STALL);
    assign o_count          = r_count;
    assign o_overflow       = r_overflow;

endmodule
